// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one I-cache request at a time, holds the
// returned word for decode, and squashes in-flight requests on redirects.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_read, imem_address        cache request (held until imem_resp)
//   imem_rdata, imem_resp          cache response word and strobe
//   redirect_en, redirect_pc       control-flow redirect from EX
//   id_ready                       IF/ID buffer accepts the presented word
//   if_valid, if_pc, if_instruction  fetched instruction toward decode
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] req_addr;
    logic [31:0] inst_q;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc_q     <= RESET_PC;
            req_addr <= RESET_PC;
            inst_q   <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (redirect_en) begin
                        pc_q <= target;
                        // A request still in flight must be drained at its
                        // original address before the new target is issued.
                        if (!imem_resp) begin
                            req_addr <= pc_q;
                            state    <= DISCARD;
                        end
                    end else if (imem_resp) begin
                        inst_q <= imem_rdata;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (redirect_en) begin
                        pc_q  <= target;
                        state <= FETCH;
                    end else if (id_ready) begin
                        pc_q  <= pc_q + 32'd4;
                        state <= FETCH;
                    end
                end
                DISCARD: begin
                    if (redirect_en) begin
                        pc_q <= target;
                    end
                    if (imem_resp) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    always_comb begin
        imem_read    = 1'b0;
        imem_address = pc_q;
        if (!rst) begin
            imem_read = (state == FETCH) || (state == DISCARD);
        end
        if (state == DISCARD) begin
            imem_address = req_addr;
        end
    end

    assign if_valid       = (state == HOLD);
    assign if_pc          = pc_q;
    assign if_instruction = inst_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: scenario tasks drive the cache and
// control inputs; delivered words are tracked in a scoreboard queue.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [63:0] exp;

    fetch_stage #(.RESET_PC(32'h0000_0060)) dut (
        .clk(clk),
        .rst(rst),
        .imem_read(imem_read),
        .imem_address(imem_address),
        .imem_rdata(imem_rdata),
        .imem_resp(imem_resp),
        .redirect_en(redirect_en),
        .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .if_valid(if_valid),
        .if_pc(if_pc),
        .if_instruction(if_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs for the next posedge, return at the following negedge.
    task automatic step(input logic r, input logic [31:0] d,
                        input logic re, input logic [31:0] rp,
                        input logic rdy);
        imem_resp   = r;
        imem_rdata  = d;
        redirect_en = re;
        redirect_pc = rp;
        id_ready    = rdy;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1234, 1'b1);
        checks++;
        if (imem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_read got %b exp 0", imem_read);
        end
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b exp 0", if_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h60, 1'b0}) begin
            errors++;
            $display("FAIL reset_first got rd=%b a=%h v=%b exp rd=1 a=60 v=0",
                     imem_read, imem_address, if_valid);
        end
    endtask

    task automatic test_basic();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_read, imem_address} !== {1'b1, 32'h60}) begin
            errors++;
            $display("FAIL basic_wait got rd=%b a=%h exp rd=1 a=60",
                     imem_read, imem_address);
        end
        sb.push_back({32'h60, 32'h13});
        step(1'b1, 32'h13, 1'b0, 32'h0, 1'b1);
        exp = sb.pop_front();
        checks++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL basic_out got v=%b pc=%h i=%h exp v=1 %h",
                     if_valid, if_pc, if_instruction, exp);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h64, 1'b0}) begin
            errors++;
            $display("FAIL basic_next got rd=%b a=%h v=%b exp rd=1 a=64 v=0",
                     imem_read, imem_address, if_valid);
        end
    endtask

    task automatic test_hold();
        int bad;
        sb.push_back({32'h64, 32'hAAAA_0001});
        step(1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 1'b0);
        exp = sb.pop_front();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if ({if_valid, if_pc, if_instruction, imem_read} !== {1'b1, exp, 1'b0})
                bad++;
            step(i[0], 32'h5555_0000, 1'b0, 32'h0, 1'b0);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable got %0d bad cycles exp 0", bad);
        end
        checks++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL hold_end got v=%b pc=%h i=%h exp %h",
                     if_valid, if_pc, if_instruction, exp);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h68, 1'b0}) begin
            errors++;
            $display("FAIL hold_next got rd=%b a=%h v=%b exp rd=1 a=68 v=0",
                     imem_read, imem_address, if_valid);
        end
    endtask

    task automatic test_redirect_pending();
        step(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h68, 1'b0}) begin
            errors++;
            $display("FAIL rdp_hold1 got rd=%b a=%h v=%b exp rd=1 a=68 v=0",
                     imem_read, imem_address, if_valid);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_read, imem_address} !== {1'b1, 32'h68}) begin
            errors++;
            $display("FAIL rdp_hold2 got rd=%b a=%h exp rd=1 a=68",
                     imem_read, imem_address);
        end
        step(1'b1, 32'hDEAD_0068, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h200, 1'b0}) begin
            errors++;
            $display("FAIL rdp_new got rd=%b a=%h v=%b exp rd=1 a=200 v=0",
                     imem_read, imem_address, if_valid);
        end
        sb.push_back({32'h200, 32'h0200_0093});
        step(1'b1, 32'h0200_0093, 1'b0, 32'h0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL rdp_out got v=%b pc=%h i=%h exp %h",
                     if_valid, if_pc, if_instruction, exp);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_redirect_coincident();
        step(1'b1, 32'hDEAD_0204, 1'b1, 32'h103, 1'b1);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL coin_next got rd=%b a=%h v=%b exp rd=1 a=100 v=0",
                     imem_read, imem_address, if_valid);
        end
        step(1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
        step(1'b0, 32'h0, 1'b1, 32'h501, 1'b1);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL disc_addr got rd=%b a=%h v=%b exp rd=1 a=100 v=0",
                     imem_read, imem_address, if_valid);
        end
        step(1'b1, 32'hDEAD_0100, 1'b0, 32'h0, 1'b0);
        checks++;
        if ({imem_address, if_valid} !== {32'h500, 1'b0}) begin
            errors++;
            $display("FAIL disc_latest got a=%h v=%b exp a=500 v=0",
                     imem_address, if_valid);
        end
        step(1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
        step(1'b1, 32'hDEAD_0500, 1'b1, 32'h700, 1'b0);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h700, 1'b0}) begin
            errors++;
            $display("FAIL disc_resp_redir got rd=%b a=%h v=%b exp rd=1 a=700 v=0",
                     imem_read, imem_address, if_valid);
        end
    endtask

    task automatic test_hold_redirect();
        sb.push_back({32'h700, 32'h0070_0013});
        step(1'b1, 32'h0070_0013, 1'b0, 32'h0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL hredir_out got v=%b pc=%h i=%h exp %h",
                     if_valid, if_pc, if_instruction, exp);
        end
        step(1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h400, 1'b0}) begin
            errors++;
            $display("FAIL hredir_next got rd=%b a=%h v=%b exp rd=1 a=400 v=0",
                     imem_read, imem_address, if_valid);
        end
    endtask

    task automatic test_wrap_and_reset();
        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 32'hDEAD_0400, 1'b0, 32'h0, 1'b0);
        sb.push_back({32'hFFFF_FFFC, 32'h1234_5678});
        step(1'b1, 32'h1234_5678, 1'b0, 32'h0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL wrap_out got v=%b pc=%h i=%h exp %h",
                     if_valid, if_pc, if_instruction, exp);
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        checks++;
        if ({imem_read, imem_address} !== {1'b1, 32'h0}) begin
            errors++;
            $display("FAIL wrap_next got rd=%b a=%h exp rd=1 a=0",
                     imem_read, imem_address);
        end
        step(1'b0, 32'h0, 1'b1, 32'h800, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (imem_read !== 1'b0) begin
            errors++;
            $display("FAIL rst_disc_read got %b exp 0", imem_read);
        end
        @(negedge clk);
        step(1'b0, 32'h0, 1'b1, 32'h900, 1'b1);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h60, 1'b0}) begin
            errors++;
            $display("FAIL rst_disc_next got rd=%b a=%h v=%b exp rd=1 a=60 v=0",
                     imem_read, imem_address, if_valid);
        end
        sb.push_back({32'h60, 32'h0BAD_F00D});
        step(1'b1, 32'h0BAD_F00D, 1'b0, 32'h0, 1'b0);
        exp = sb.pop_front();
        checks++;
        if ({if_valid, if_pc, if_instruction} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL rst_resp got v=%b pc=%h i=%h exp %h",
                     if_valid, if_pc, if_instruction, exp);
        end
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_read, imem_address, if_valid} !== {1'b1, 32'h60, 1'b0}) begin
            errors++;
            $display("FAIL rst_hold got rd=%b a=%h v=%b exp rd=1 a=60 v=0",
                     imem_read, imem_address, if_valid);
        end
    endtask

    initial begin
        rst         = 1'b1;
        imem_resp   = 1'b0;
        imem_rdata  = '0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_redirect_pending();
        test_redirect_coincident();
        test_hold_redirect();
        test_wrap_and_reset();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_empty got %0d exp 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
